mavg_burst_ctrl: RTL and testbench
==================================

// Module: mavg_burst_ctrl
// PURPOSE
//  Sequences one moving_avg instance for burst measurements (e.g. power/plateau estimates).
//  On start: clears the averager, feeds it samples, waits out the window warm-up, then forwards
//  exactly num_samples averaged outputs and pulses done. Supports abort and stall timeout.
//  Sits between the sample source and a moving_avg instance; it owns that instance's reset and enable.
// PARAMETERS
//  DATA_WIDTH     32  sample/average width; must match the averager's DATA_WIDTH
//  COUNT_WIDTH    16  width of num_samples and of the output counter
//  TIMEOUT_WIDTH  16  width of timeout_cycles and of the idle-gap counter
// PORTS
//  clock             in   1              system clock
//  reset             in   1              synchronous, active-high
//  start             in   1              start a burst; honoured in IDLE only
//  abort             in   1              cancel the current burst
//  num_samples       in   COUNT_WIDTH    averaged outputs to deliver; latched on start
//  timeout_cycles    in   TIMEOUT_WIDTH  max gap between sample_strobe pulses; 0 = disabled; latched on start
//  sample_in         in   DATA_WIDTH     signed input sample
//  sample_strobe     in   1              sample_in valid
//  avg_reset         out  1              averager reset
//  avg_enable        out  1              averager enable
//  avg_data_in       out  DATA_WIDTH     = sample_in (combinational)
//  avg_input_strobe  out  1              sample_strobe gated by FILL|RUN
//  avg_data_out      in   DATA_WIDTH     averager result
//  avg_output_strobe in   1              averager result valid (window full)
//  data_out          out  DATA_WIDTH     forwarded average, registered
//  output_strobe     out  1              data_out valid, 1-cycle pulse
//  busy              out  1              state != IDLE
//  done              out  1              1-cycle pulse: burst completed normally
//  timeout           out  1              1-cycle pulse: burst ended by stall
// BEHAVIOUR
//  States: IDLE, CLEAR, FILL, RUN, DONE, ABORT (registered FSM).
//  Reset values: data_out=0; output_strobe=done=timeout=busy=0; state=IDLE; counters=0.
//   avg_reset=1 while reset is high.
//  avg_reset = reset | (state==CLEAR) | (state==ABORT).  avg_enable = state in {FILL,RUN}.
//  IDLE:  on start, latch num_samples and timeout_cycles, clear counters -> CLEAR.
//  CLEAR: 1 cycle -> FILL; if latched num_samples==0 -> DONE instead (no outputs).
//  FILL:  forward strobes; first avg_output_strobe -> RUN; that output counts as output #1.
//  RUN:   each avg_output_strobe with out_cnt < num_samples: data_out<=avg_data_out,
//   output_strobe=1 the next cycle (latency 1), out_cnt++.
//   When out_cnt reaches num_samples -> DONE. Surplus averager outputs are dropped.
//  DONE:  done=1 for one cycle -> IDLE.
//  ABORT: avg_reset=1 for one cycle; timeout=1 if entered by stall -> IDLE.
//  Stall: in FILL/RUN, gap counter clears on sample_strobe, else increments.
//   If timeout_cycles!=0 and gap reaches timeout_cycles -> ABORT (timeout).
//  Abort: abort in any non-IDLE state -> ABORT (no done, no timeout). In IDLE, abort is ignored.
//  Priority: reset > abort > timeout > normal. An abort in the same cycle as the final
//   avg_output_strobe drops that output and suppresses done.
//  start while busy is ignored; start and abort together in IDLE: start wins.
//  Samples are forwarded only in FILL/RUN; samples in IDLE/CLEAR/DONE/ABORT are discarded.
//  Counters saturate at the top value and never wrap.
// TESTING (averager model WINDOW_SHIFT=4: first avg_output_strobe 1 cycle after 17th input strobe)
//  1) num_samples=5, strobe every cycle -> avg_reset 1 cycle after start; exactly 5 output_strobes,
//     each 1 cycle after avg_output_strobe; done pulse; busy falls with it; later averages dropped.
//  2) num_samples=0 -> IDLE,CLEAR,DONE; done 2 cycles after start; no output_strobe.
//  3) timeout_cycles=8; stop strobes after 10 samples -> timeout pulse on the 8th idle cycle;
//     avg_reset 1 cycle; no done; busy=0 afterwards.
//  4) abort during RUN after 3 outputs -> no further output_strobe; avg_reset pulse; no done/timeout.
//  5) start during RUN and abort in IDLE -> both ignored; burst output count unchanged.
//  6) reset mid-FILL -> all outputs at reset values next cycle; a new start runs a full clean burst.

Source files
------------

// File: rtl/mavg_burst_ctrl.sv
// mavg_burst_ctrl: runs one moving-average instance through a measurement burst.
// Owns the averager's reset/enable, waits out warm-up and forwards a fixed number of results.
module mavg_burst_ctrl #(
   parameter int DATA_WIDTH    = 32,
   parameter int COUNT_WIDTH   = 16,
   parameter int TIMEOUT_WIDTH = 16
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     start,
   input  logic                     abort,
   input  logic [COUNT_WIDTH-1:0]   num_samples,
   input  logic [TIMEOUT_WIDTH-1:0] timeout_cycles,
   input  logic [DATA_WIDTH-1:0]    sample_in,
   input  logic                     sample_strobe,
   output logic                     avg_reset,
   output logic                     avg_enable,
   output logic [DATA_WIDTH-1:0]    avg_data_in,
   output logic                     avg_input_strobe,
   input  logic [DATA_WIDTH-1:0]    avg_data_out,
   input  logic                     avg_output_strobe,
   output logic [DATA_WIDTH-1:0]    data_out,
   output logic                     output_strobe,
   output logic                     busy,
   output logic                     done,
   output logic                     timeout
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_FILL,
      S_RUN,
      S_DONE,
      S_ABORT
   } state_t;

   state_t                   state;
   state_t                   state_next;
   logic [COUNT_WIDTH-1:0]   num_lat;
   logic [COUNT_WIDTH-1:0]   out_cnt;
   logic [TIMEOUT_WIDTH-1:0] to_lat;
   logic [TIMEOUT_WIDTH-1:0] gap_cnt;
   logic [TIMEOUT_WIDTH-1:0] gap_inc;
   logic                     stall_flag;
   logic                     active;
   logic                     stall_hit;
   logic                     take_output;
   logic                     last_output;

   // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      active      = (state == S_FILL) || (state == S_RUN);
      gap_inc     = (gap_cnt == '1) ? gap_cnt : gap_cnt + TIMEOUT_WIDTH'(1);
      stall_hit   = active && !sample_strobe && (to_lat != '0) && (gap_inc >= to_lat);
      take_output = active && !abort && !stall_hit && avg_output_strobe && (out_cnt < num_lat);
      last_output = (out_cnt == num_lat - COUNT_WIDTH'(1));
      state_next  = state;
      case (state)
         S_IDLE:  if (start) state_next = S_CLEAR;
         S_CLEAR: begin
            if (abort)               state_next = S_ABORT;
            else if (num_lat == '0)  state_next = S_DONE;
            else                     state_next = S_FILL;
         end
         S_FILL, S_RUN: begin
            if (abort || stall_hit)  state_next = S_ABORT;
            else if (take_output)    state_next = last_output ? S_DONE : S_RUN;
         end
         S_DONE:  state_next = abort ? S_ABORT : S_IDLE;
         S_ABORT: state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) state <= S_IDLE;
      else       state <= state_next;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         num_lat       <= '0;
         to_lat        <= '0;
         out_cnt       <= '0;
         gap_cnt       <= '0;
         stall_flag    <= 1'b0;
         data_out      <= '0;
         output_strobe <= 1'b0;
      end else begin
         output_strobe <= take_output;
         // Remembered for one cycle so ABORT can tell a stall from an explicit abort.
         stall_flag    <= stall_hit && !abort;
         if (take_output) begin
            data_out <= avg_data_out;
            out_cnt  <= out_cnt + COUNT_WIDTH'(1);
         end
         if (state == S_IDLE && start) begin
            num_lat <= num_samples;
            to_lat  <= timeout_cycles;
            out_cnt <= '0;
            gap_cnt <= '0;
         end else if (active) begin
            gap_cnt <= sample_strobe ? '0 : gap_inc;
         end
      end
   end

   assign avg_reset        = reset || (state == S_CLEAR) || (state == S_ABORT);
   assign avg_enable       = active;
   assign avg_data_in      = sample_in;
   assign avg_input_strobe = sample_strobe && active;
   assign busy             = (state != S_IDLE);
   assign done             = (state == S_DONE);
   assign timeout          = (state == S_ABORT) && stall_flag;

endmodule

// File: tb/tb_mavg_burst_ctrl.sv
// tb_mavg_burst_ctrl: closed-loop bench with a 16-deep averager stub, directed vectors,
// multi-cycle corner sequences and a randomized run scored against a burst-level model.
module tb_mavg_burst_ctrl;

   localparam int DW = 32;
   localparam int CW = 16;
   localparam int TW = 16;

   logic          clock = 1'b0;
   logic          reset;
   logic          start;
   logic          abort;
   logic [CW-1:0] num_samples;
   logic [TW-1:0] timeout_cycles;
   logic [DW-1:0] sample_in;
   logic          sample_strobe;
   logic          avg_reset;
   logic          avg_enable;
   logic [DW-1:0] avg_data_in;
   logic          avg_input_strobe;
   logic [DW-1:0] avg_data_out = '0;
   logic          avg_output_strobe = 1'b0;
   logic [DW-1:0] data_out;
   logic          output_strobe;
   logic          busy;
   logic          done;
   logic          timeout;

   int n_cmp  = 0;
   int n_fail = 0;
   bit sb_en  = 1'b0;

   always #5 clock = ~clock;

   mavg_burst_ctrl #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW), .TIMEOUT_WIDTH(TW)) dut (
      .clock(clock), .reset(reset), .start(start), .abort(abort),
      .num_samples(num_samples), .timeout_cycles(timeout_cycles),
      .sample_in(sample_in), .sample_strobe(sample_strobe),
      .avg_reset(avg_reset), .avg_enable(avg_enable), .avg_data_in(avg_data_in),
      .avg_input_strobe(avg_input_strobe), .avg_data_out(avg_data_out),
      .avg_output_strobe(avg_output_strobe), .data_out(data_out),
      .output_strobe(output_strobe), .busy(busy), .done(done), .timeout(timeout)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Averager stub: 16-sample window, result valid one cycle after the 17th input.
   logic signed [DW-1:0] st_win [16];
   int                   st_cnt;
   int                   st_wp;
   longint               st_sum;
   longint               st_avg;
   always @(posedge clock) begin
      if (avg_reset) begin
         for (int i = 0; i < 16; i++) st_win[i] = '0;
         st_cnt = 0;
         st_wp  = 0;
         avg_output_strobe <= 1'b0;
         avg_data_out      <= '0;
      end else if (avg_enable && avg_input_strobe) begin
         st_win[st_wp] = avg_data_in;
         st_wp  = (st_wp + 1) % 16;
         st_cnt++;
         st_sum = 0;
         for (int i = 0; i < 16; i++) st_sum += longint'(st_win[i]);
         st_avg = st_sum >>> 4;
         avg_output_strobe <= (st_cnt >= 17);
         avg_data_out      <= st_avg[DW-1:0];
      end else begin
         avg_output_strobe <= 1'b0;
      end
   end

   // Burst-level reference: a burst is "clearing" for its first cycle, then "collecting"
   // until it has delivered n results, stalled, or been cancelled.
   bit            m_in_burst, m_clearing, m_done_p, m_abort_p, m_stall, m_ostb;
   bit            nd, na, ns;
   int            m_n, m_to, m_delivered, m_gap, gap_next;
   logic [DW-1:0] m_data = '0;
   always @(posedge clock) begin
      if (reset) begin
         m_in_burst = 0; m_clearing = 0; m_done_p = 0; m_abort_p = 0; m_stall = 0;
         m_ostb = 0; m_data = '0; m_delivered = 0; m_gap = 0;
      end else begin
         nd = 0; na = 0; ns = 0;
         m_ostb = 0;
         if (m_done_p || m_abort_p) begin
            if (m_done_p && abort) na = 1;
         end else if (!m_in_burst) begin
            if (start) begin
               m_in_burst = 1; m_clearing = 1;
               m_n = int'(num_samples); m_to = int'(timeout_cycles);
               m_delivered = 0; m_gap = 0;
            end
         end else if (m_clearing) begin
            if (abort) na = 1;
            else if (m_n == 0) nd = 1;
            m_clearing = 0;
         end else begin
            gap_next = sample_strobe ? 0 : ((m_gap < 65535) ? m_gap + 1 : m_gap);
            if (abort) na = 1;
            else if (!sample_strobe && m_to != 0 && gap_next >= m_to) begin
               na = 1; ns = 1;
            end else if (avg_output_strobe && m_delivered < m_n) begin
               m_data = avg_data_out;
               m_ostb = 1;
               m_delivered++;
               if (m_delivered == m_n) nd = 1;
            end
            m_gap = gap_next;
         end
         if (na || nd) m_in_burst = 0;
         m_done_p = nd; m_abort_p = na; m_stall = ns;
      end
   end

   bit e_en;
   always @(negedge clock) begin
      if (sb_en) begin
         e_en = m_in_burst && !m_clearing;
         check("sb_busy", busy, m_in_burst || m_done_p || m_abort_p);
         check("sb_done", done, m_done_p);
         check("sb_timeout", timeout, m_abort_p && m_stall);
         check("sb_avg_reset", avg_reset, reset || (m_in_burst && m_clearing) || m_abort_p);
         check("sb_avg_enable", avg_enable, e_en);
         check("sb_avg_input_strobe", avg_input_strobe, e_en && sample_strobe);
         check("sb_avg_data_in", avg_data_in, sample_in);
         check("sb_output_strobe", output_strobe, m_ostb);
         check("sb_data_out", data_out, m_data);
      end
   end

   typedef struct {
      logic          start, abort, strobe;
      logic [CW-1:0] num;
      logic [TW-1:0] to;
      logic          busy, done, timeout, a_rst, a_en, a_istb, ostb;
   } vec_t;

   // Runs one burst with a continuous strobe of samples 16*k; optionally pokes start mid-burst.
   task automatic run_burst(input int n, input int poke_at, output int n_out, output int n_done);
      int  k = 1;
      int  since_done = 0;
      bit  prev_aostb = 0;
      bit  after_done = 0;
      bit  poked = 0;
      n_out = 0; n_done = 0;
      start = 1; num_samples = CW'(n); timeout_cycles = '0; sample_strobe = 0;
      step();
      check("burst_avg_reset_after_start", avg_reset, 1);
      start = 0;
      step();
      for (int cyc = 0; cyc < 200; cyc++) begin
         sample_strobe = 1;
         sample_in = DW'(16 * k);
         k++;
         if (poke_at >= 0 && n_out == poke_at && !poked) begin
            start = 1; num_samples = 9; poked = 1;
         end else start = 0;
         step();
         if (after_done) begin
            check("busy_after_done", busy, 0);
            after_done = 0;
         end
         if (output_strobe) begin
            n_out++;
            check("out_lag", prev_aostb, 1);
            check("out_data", data_out, 136 + 16 * n_out);
         end
         if (done) begin
            n_done++;
            after_done = 1;
         end
         prev_aostb = avg_output_strobe;
         if (n_done > 0) since_done++;
         if (since_done >= 20) break;
      end
      start = 0;
      sample_strobe = 0;
   endtask

   initial begin
      vec_t tbl[11];
      int n_out, n_done, n_to, t_cyc, cnt;

      reset = 1; start = 0; abort = 0; num_samples = '0; timeout_cycles = '0;
      sample_in = '0; sample_strobe = 0;
      step();
      sb_en = 1;
      step();
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_timeout", timeout, 0);
      check("rst_output_strobe", output_strobe, 0);
      check("rst_data_out", data_out, 0);
      check("rst_avg_reset", avg_reset, 1);
      reset = 0;
      step();

      // start, abort, strobe, num, to | busy, done, timeout, a_rst, a_en, a_istb, ostb
      tbl[0]  = '{1'b1, 1'b0, 1'b1, 16'd0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[1]  = '{1'b0, 1'b0, 1'b1, 16'd0, 16'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[2]  = '{1'b0, 1'b0, 1'b1, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[3]  = '{1'b0, 1'b1, 1'b1, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[4]  = '{1'b1, 1'b1, 1'b0, 16'd0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[5]  = '{1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[6]  = '{1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[7]  = '{1'b1, 1'b0, 1'b1, 16'd3, 16'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[8]  = '{1'b0, 1'b0, 1'b1, 16'd3, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      tbl[9]  = '{1'b0, 1'b1, 1'b1, 16'd3, 16'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[10] = '{1'b0, 1'b0, 1'b0, 16'd3, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      for (int i = 0; i < 11; i++) begin
         start = tbl[i].start; abort = tbl[i].abort; sample_strobe = tbl[i].strobe;
         num_samples = tbl[i].num; timeout_cycles = tbl[i].to; sample_in = DW'(i);
         step();
         check($sformatf("vec%0d_busy", i), busy, tbl[i].busy);
         check($sformatf("vec%0d_done", i), done, tbl[i].done);
         check($sformatf("vec%0d_timeout", i), timeout, tbl[i].timeout);
         check($sformatf("vec%0d_avg_reset", i), avg_reset, tbl[i].a_rst);
         check($sformatf("vec%0d_avg_enable", i), avg_enable, tbl[i].a_en);
         check($sformatf("vec%0d_avg_input_strobe", i), avg_input_strobe, tbl[i].a_istb);
         check($sformatf("vec%0d_output_strobe", i), output_strobe, tbl[i].ostb);
      end
      start = 0; abort = 0; sample_strobe = 0;
      step();

      // Five outputs with a start poked in mid-RUN that must not re-latch anything.
      run_burst(5, 2, n_out, n_done);
      check("burst5_outputs", n_out, 5);
      check("burst5_done", n_done, 1);

      // Stall: ten samples then silence with an 8-cycle limit.
      start = 1; num_samples = 5; timeout_cycles = 8;
      step();
      start = 0;
      step();
      for (int i = 1; i <= 10; i++) begin
         sample_strobe = 1; sample_in = DW'(i);
         step();
      end
      sample_strobe = 0;
      t_cyc = -1; n_to = 0; n_done = 0;
      for (int c = 1; c <= 15; c++) begin
         step();
         if (timeout) begin
            n_to++;
            if (t_cyc < 0) t_cyc = c;
            check("stall_avg_reset", avg_reset, 1);
         end
         if (done) n_done++;
      end
      check("stall_timeout_cycle", t_cyc, 8);
      check("stall_timeout_count", n_to, 1);
      check("stall_no_done", n_done, 0);
      check("stall_busy_after", busy, 0);

      // Abort during RUN after three outputs.
      start = 1; num_samples = 10; timeout_cycles = 0;
      step();
      start = 0;
      step();
      n_out = 0; cnt = 0;
      while (n_out < 3 && cnt < 100) begin
         sample_strobe = 1; sample_in = DW'(cnt * 3);
         step();
         if (output_strobe) n_out++;
         cnt++;
      end
      check("abort_reached_three", n_out, 3);
      abort = 1;
      step();
      abort = 0;
      check("abort_avg_reset", avg_reset, 1);
      check("abort_no_timeout", timeout, 0);
      check("abort_drops_output", output_strobe, 0);
      n_done = 0; n_to = 0;
      for (int c = 0; c < 20; c++) begin
         step();
         if (output_strobe) n_out++;
         if (done) n_done++;
         if (timeout) n_to++;
      end
      sample_strobe = 0;
      check("abort_outputs", n_out, 3);
      check("abort_no_done", n_done, 0);
      check("abort_no_timeout_later", n_to, 0);
      check("abort_busy_after", busy, 0);

      // Reset mid-FILL, then a clean burst.
      start = 1; num_samples = 3;
      step();
      start = 0;
      step();
      for (int i = 0; i < 5; i++) begin
         sample_strobe = 1; sample_in = DW'(i + 100);
         step();
      end
      reset = 1;
      step();
      check("midreset_busy", busy, 0);
      check("midreset_output_strobe", output_strobe, 0);
      check("midreset_data_out", data_out, 0);
      check("midreset_done", done, 0);
      check("midreset_timeout", timeout, 0);
      check("midreset_avg_reset", avg_reset, 1);
      check("midreset_avg_enable", avg_enable, 0);
      reset = 0; sample_strobe = 0;
      step();
      run_burst(2, -1, n_out, n_done);
      check("postreset_outputs", n_out, 2);
      check("postreset_done", n_done, 1);

      // Randomized traffic at three strobe densities.
      for (int seg = 0; seg < 3; seg++) begin
         for (int c = 0; c < 1000; c++) begin
            reset          = ($urandom_range(0, 999) == 0);
            start          = ($urandom_range(0, 7) == 0);
            abort          = ($urandom_range(0, 249) == 0);
            sample_strobe  = ($urandom_range(0, 99) < (seg == 0 ? 95 : (seg == 1 ? 80 : 60)));
            sample_in      = DW'($urandom_range(0, 4000)) - DW'(2000);
            num_samples    = CW'($urandom_range(0, 6));
            timeout_cycles = ($urandom_range(0, 3) == 0) ? '0 : TW'($urandom_range(3, 10));
            step();
         end
      end
      reset = 0; start = 0; abort = 0; sample_strobe = 0;
      repeat (3) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, expected completion before 500000");
      $fatal(1);
   end

endmodule
